// File: rtl/fma_memory.sv
// Line-oriented data memory between the instruction decoder and the FMA blocks.
// Builds/stores 96-bit lines in a block RAM and reads them back as packed a/b/c operands.
module fma_memory #(
   parameter int FMA_COUNT         = 2,
   parameter int WORD_WIDTH        = 16,
   parameter int LINE_WIDTH        = FMA_COUNT * 3 * WORD_WIDTH,
   parameter int ADDR_LENGTH       = 9,
   parameter int INSTRUCTION_WIDTH = 32
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [LINE_WIDTH-1:0]        buffer_read_in,
   input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
   input  logic                         instr_valid_in,
   output logic [LINE_WIDTH-1:0]        abc_out,
   output logic                         abc_valid_out
);

   localparam int WORDS = FMA_COUNT * 3;
   localparam int DEPTH = 2 ** ADDR_LENGTH;

   localparam logic [3:0] OP_SMA    = 4'b0110;
   localparam logic [3:0] OP_LOADI  = 4'b0111;
   localparam logic [3:0] OP_COMMIT = 4'b1110;
   localparam logic [3:0] OP_STOREB = 4'b1010;
   localparam logic [3:0] OP_READ   = 4'b1100;

   logic [3:0]             opcode_s;
   logic [3:0]             reg_a_s;
   logic [15:0]            imm_s;
   logic                   unused_s;

   logic [ADDR_LENGTH-1:0] addr_q,    addr_d;
   logic [LINE_WIDTH-1:0]  staging_q, staging_d;
   logic                   wr_en_q,   wr_en_d;
   logic [ADDR_LENGTH-1:0] wr_addr_q, wr_addr_d;
   logic [LINE_WIDTH-1:0]  wr_data_q, wr_data_d;
   logic                   rd_req_q,  rd_req_d;
   logic [ADDR_LENGTH-1:0] rd_addr_q, rd_addr_d;

   logic [ADDR_LENGTH-1:0] ram_addr_q;
   logic                   rd_v1_q;
   logic                   rd_v2_q;
   logic [LINE_WIDTH-1:0]  ram_rdata_q;
   logic [LINE_WIDTH-1:0]  mem_q [DEPTH];
   logic [LINE_WIDTH-1:0]  abc_q;
   logic                   abc_valid_q;

   assign opcode_s = instr_in[31:28];
   assign reg_a_s  = instr_in[27:24];
   assign imm_s    = instr_in[23:8];
   assign unused_s = ^instr_in[7:0];

   // Decode the accepted instruction into architectural updates and write/read requests.
   always_comb begin
      addr_d    = addr_q;
      staging_d = staging_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_req_d  = 1'b0;
      rd_addr_d = rd_addr_q;
      if (instr_valid_in) begin
         case (opcode_s)
            OP_SMA: begin
               addr_d = imm_s[ADDR_LENGTH-1:0];
            end
            OP_LOADI: begin
               // Out-of-range word selects match no slot and leave the line untouched.
               for (int w = 0; w < WORDS; w++) begin
                  if (reg_a_s == 4'(w)) begin
                     staging_d[w*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(imm_s);
                  end else begin
                     staging_d[w*WORD_WIDTH +: WORD_WIDTH] = staging_q[w*WORD_WIDTH +: WORD_WIDTH];
                  end
               end
            end
            OP_COMMIT: begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = staging_q;
            end
            OP_STOREB: begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = buffer_read_in;
            end
            OP_READ: begin
               rd_req_d  = 1'b1;
               rd_addr_d = addr_q;
            end
            default: begin
               rd_req_d = 1'b0;
            end
         endcase
      end else begin
         wr_en_d  = 1'b0;
         rd_req_d = 1'b0;
      end
   end

   // Architectural state and the registered write/read requests.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         addr_q    <= '0;
         staging_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_req_q  <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         addr_q    <= addr_d;
         staging_q <= staging_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_req_q  <= rd_req_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   // Read pipeline control: RAM address register and valid tokens.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ram_addr_q <= '0;
         rd_v1_q    <= 1'b0;
         rd_v2_q    <= 1'b0;
      end else begin
         ram_addr_q <= rd_addr_q;
         rd_v1_q    <= rd_req_q;
         rd_v2_q    <= rd_v1_q;
      end
   end

   // Block RAM: contents survive reset; a same-edge write and read returns the old line.
   always_ff @(posedge clk_in) begin
      if (wr_en_q) begin
         mem_q[wr_addr_q] <= wr_data_q;
      end
      ram_rdata_q <= mem_q[ram_addr_q];
   end

   // Output register: holds the last read line, pulses valid when a new one lands.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         abc_q       <= '0;
         abc_valid_q <= 1'b0;
      end else begin
         abc_valid_q <= rd_v2_q;
         if (rd_v2_q) begin
            abc_q <= ram_rdata_q;
         end else begin
            abc_q <= abc_q;
         end
      end
   end

   assign abc_out       = abc_q;
   assign abc_valid_out = abc_valid_q;

endmodule

// File: tb/tb_fma_memory.sv
// Randomized self-checking bench for fma_memory against a line-level reference model.
module tb_fma_memory;

   logic         clk_in = 1'b0;
   logic         rst_in;
   logic [95:0]  buffer_read_in;
   logic [31:0]  instr_in;
   logic         instr_valid_in;
   logic [95:0]  abc_out;
   logic         abc_valid_out;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int          due;
      logic [95:0] data;
   } rd_t;

   rd_t          pend[$];
   logic [95:0]  mem_m [int];
   logic [15:0]  stg_m [6];
   int           addr_m;
   logic [95:0]  last_m;
   logic         exp_v;
   int           addrs [8] = '{0, 1, 2, 255, 256, 376, 510, 511};

   fma_memory dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .buffer_read_in (buffer_read_in),
      .instr_in       (instr_in),
      .instr_valid_in (instr_valid_in),
      .abc_out        (abc_out),
      .abc_valid_out  (abc_valid_out)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [95:0] staging_line();
      logic [95:0] l;
      l = '0;
      for (int i = 0; i < 6; i++) l[16*i +: 16] = stg_m[i];
      return l;
   endfunction

   task automatic model_reset();
      pend.delete();
      addr_m = 0;
      for (int i = 0; i < 6; i++) stg_m[i] = 16'h0000;
      last_m = '0;
   endtask

   task automatic model_apply(input logic [3:0] op, input logic [3:0] ra,
                              input logic [15:0] imm, input logic [95:0] bufv);
      rd_t r;
      case (op)
         4'b0110: addr_m = int'(imm) % 512;
         4'b0111: if (int'(ra) < 6) stg_m[int'(ra)] = imm;
         4'b1110: mem_m[addr_m] = staging_line();
         4'b1010: mem_m[addr_m] = bufv;
         4'b1100: begin
            r.due  = cyc + 3;
            r.data = mem_m.exists(addr_m) ? mem_m[addr_m] : 96'd0;
            pend.push_back(r);
         end
         default: ;
      endcase
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] ra, input logic [15:0] imm,
                        input logic [95:0] bufv, input bit vld);
      instr_in       = {op, ra, imm, 8'h5A};
      buffer_read_in = bufv;
      instr_valid_in = vld;
      @(posedge clk_in);
      #1;
      if (vld) model_apply(op, ra, imm, bufv);
      instr_valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   // Every cycle: valid must pulse exactly when a modelled read is due; abc_out holds otherwise.
   always @(negedge clk_in) begin
      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      check("abc_valid_out", {95'd0, abc_valid_out}, {95'd0, exp_v});
      if (exp_v) begin
         last_m = pend[0].data;
         void'(pend.pop_front());
      end
      check("abc_out", abc_out, last_m);
   end

   initial begin
      logic [3:0]  op;
      logic [15:0] imm;
      logic [95:0] bufv;
      int          sel;

      model_reset();
      rst_in         = 1'b0;
      instr_in       = 32'h0;
      instr_valid_in = 1'b0;
      buffer_read_in = 96'd0;
      idle(3);
      rst_in = 1'b1;
      idle(1);

      // Nonzero READ word with valid low must do nothing.
      for (int i = 0; i < 4; i++) issue(4'b1100, 4'h0, 16'h0000, 96'd0, 1'b0);
      idle(4);

      issue(4'b0110, 4'h0, 16'h0178, 96'd0, 1'b1);
      for (int i = 0; i < 6; i++) issue(4'b0111, 4'(i), 16'h8888 - 16'(i), 96'd0, 1'b1);
      issue(4'b1110, 4'h0, 16'h0000, 96'd0, 1'b1);
      issue(4'b1100, 4'h0, 16'h0000, 96'd0, 1'b1);
      idle(4);
      check("build_commit_read", abc_out, 96'h8883_8884_8885_8886_8887_8888);

      issue(4'b1010, 4'h0, 16'h0000, 96'hA000_A000_A000_A000_A000_A000, 1'b1);
      issue(4'b1100, 4'h0, 16'h0000, 96'd0, 1'b1);
      idle(4);
      check("storeb_read", abc_out, 96'hA000_A000_A000_A000_A000_A000);

      issue(4'b0110, 4'h0, 16'h0578, 96'd0, 1'b1);
      for (int i = 0; i < 6; i++) issue(4'b0111, 4'(i), 16'hC888 - 16'(i), 96'd0, 1'b1);
      issue(4'b1110, 4'h0, 16'h0000, 96'd0, 1'b1);
      issue(4'b1100, 4'h0, 16'h0000, 96'd0, 1'b1);
      idle(4);
      check("addr_trunc_commit", abc_out, 96'hC883_C884_C885_C886_C887_C888);
      issue(4'b1010, 4'h0, 16'h0000, 96'hAA00_A000_A000_A000_A000_A000, 1'b1);
      issue(4'b1100, 4'h0, 16'h0000, 96'd0, 1'b1);
      idle(4);
      check("addr_trunc_storeb", abc_out, 96'hAA00_A000_A000_A000_A000_A000);

      issue(4'b0111, 4'h6, 16'hDEAD, 96'd0, 1'b1);
      issue(4'b1111, 4'h1, 16'hBEEF, 96'hFFFF_0000_FFFF_0000_FFFF_0000, 1'b1);
      issue(4'b1110, 4'h0, 16'h0000, 96'd0, 1'b1);
      issue(4'b1100, 4'h0, 16'h0000, 96'd0, 1'b1);
      idle(4);
      check("loadi_oob_nop", abc_out, 96'hC883_C884_C885_C886_C887_C888);

      // Seed every reachable address so random reads only see written lines.
      for (int k = 0; k < 8; k++) begin
         issue(4'b0110, 4'h0, 16'(addrs[k]), 96'd0, 1'b1);
         issue(4'b1010, 4'h0, 16'h0000, {$urandom, $urandom, $urandom}, 1'b1);
      end

      for (int n = 0; n < 600; n++) begin
         sel  = $urandom_range(0, 9);
         imm  = 16'($urandom);
         bufv = {$urandom, $urandom, $urandom};
         case (sel)
            0, 1: begin
               imm[8:0] = 9'(addrs[$urandom_range(0, 7)]);
               op = 4'b0110;
            end
            2, 3: op = 4'b0111;
            4:    op = 4'b1110;
            5:    op = 4'b1010;
            6, 7: op = 4'b1100;
            8:    op = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'b0000;
            default: op = 4'b1100;
         endcase
         issue(op, 4'($urandom_range(0, 7)), imm, bufv, sel != 9);
      end
      idle(5);

      // Reset one cycle after a READ kills the in-flight read; RAM contents survive.
      issue(4'b0110, 4'h0, 16'h0000, 96'd0, 1'b1);
      for (int i = 0; i < 6; i++) issue(4'b0111, 4'(i), 16'h1230 + 16'(i), 96'd0, 1'b1);
      issue(4'b1110, 4'h0, 16'h0000, 96'd0, 1'b1);
      issue(4'b0110, 4'h0, 16'h0178, 96'd0, 1'b1);
      issue(4'b1100, 4'h0, 16'h0000, 96'd0, 1'b1);
      idle(1);
      rst_in = 1'b0;
      model_reset();
      #1;
      check("reset_abc_out", abc_out, 96'd0);
      check("reset_abc_valid", {95'd0, abc_valid_out}, 96'd0);
      idle(2);
      rst_in = 1'b1;
      idle(5);
      issue(4'b1100, 4'h0, 16'h0000, 96'd0, 1'b1);
      idle(4);
      check("post_reset_ram0", abc_out, 96'h1235_1234_1233_1232_1231_1230);
      issue(4'b1110, 4'h0, 16'h0000, 96'd0, 1'b1);
      issue(4'b1100, 4'h0, 16'h0000, 96'd0, 1'b1);
      idle(4);
      check("post_reset_staging_zero", abc_out, 96'd0);

      idle(3);
      check("reads_drained", 96'(pend.size()), 96'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fma_memory.md
# fma_memory

Line-oriented data memory for the GPU datapath. It sits between the instruction decoder and the FMA blocks. It executes memory opcodes from the instruction stream to:
- set an address;
- build a line one immediate word at a time;
- commit the built line to storage;
- store an FMA result line;
- read a line out to the FMAs as packed a/b/c operands.

Storage is one block RAM of 96-bit lines, with a 2-cycle read latency.

## Interface
- FMA_COUNT, 2: FMAs served per line; a line holds FMA_COUNT*3 words.
- WORD_WIDTH, 16: bits per word.
- LINE_WIDTH, 96: bits per line (FMA_COUNT*3*WORD_WIDTH).
- ADDR_LENGTH, 9: line address width; depth is 2**ADDR_LENGTH lines.
- INSTRUCTION_WIDTH, 32: instruction width.
- clk_in  input  1  single clock; all state changes on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- buffer_read_in  input  LINE_WIDTH  FMA result line, sampled with opcode STOREB.
- instr_in  input  INSTRUCTION_WIDTH  instruction word.
- instr_valid_in  input  1  instr_in is valid this cycle.
- abc_out  output  LINE_WIDTH  line read out for the FMAs.
- abc_valid_out  output  1  one-cycle pulse when abc_out holds new read data.

## Operation
- Instruction fields:
  - [31:28] opcode
  - [27:24] reg_a
  - [23:8] imm16
  - [7:4] and [3:0] are unused here.
- An instruction is accepted on any rising edge with instr_valid_in=1. One instruction is accepted per cycle, back-to-back allowed.
- Line layout: word i occupies bits [16i+15:16i], with word 0 at the LSB. Words 3k..3k+2 are a, b, c for FMA k.
- 4'b0110 SMA: address register <= imm16[ADDR_LENGTH-1:0]; upper immediate bits are ignored.
- 4'b0111 LOADI: staging-line word reg_a <= imm16. If reg_a >= FMA_COUNT*3, the instruction is ignored.
- 4'b1110 COMMIT: RAM[address] <= staging line.
  - reg_a and imm16 are ignored.
  - The staging line is retained, not cleared.
- 4'b1010 STOREB: RAM[address] <= buffer_read_in, sampled on the accepting edge.
- 4'b1100 READ: RAM[address] is driven onto abc_out, and abc_valid_out pulses.
- All other opcodes are no-ops. Instructions with instr_valid_in=0 are ignored.
- All opcodes use the address register value in effect at acceptance. An SMA takes effect for the following instruction.
- RAM contents are zero at configuration and are not cleared by reset.

## Timing
- Reset (rst_in=0, asynchronous) clears:
  - abc_out = 0, abc_valid_out = 0;
  - address = 0;
  - staging line = 0;
  - the read pipeline, so in-flight reads produce no pulse after reset releases.
- SMA and LOADI: state is updated at the accepting edge N.
- COMMIT and STOREB: the RAM write is performed at edge N+1.
- READ accepted at edge N:
  - RAM address is registered at N+1;
  - data appears at N+2;
  - the output register loads at N+3, so abc_valid_out=1 for exactly the cycle following edge N+3.
- abc_out holds its last read value until the next read completes.
- Read-after-write: a READ accepted at least one cycle after a COMMIT or STOREB returns the new line. Same-cycle conflict is impossible because only one instruction is accepted per cycle.
- Back-to-back READs produce back-to-back valid pulses, in order.
- A write accepted while a read is in flight does not alter that read's returned data.

## Test plan
- Reset, then idle: abc_out=0, abc_valid_out=0; no pulse with instr_valid_in=0 even if instr_in is nonzero.
- Build, commit and read:
  - stimulus: SMA imm 16'h0178 (address 376); LOADI words 0..5 = 8888, 8887, 8886, 8885, 8884, 8883; COMMIT; READ.
  - required response: abc_out = 96'h8883_8884_8885_8886_8887_8888 with a one-cycle valid pulse 3 cycles after READ acceptance.
- STOREB then read:
  - stimulus: STOREB with buffer_read_in = 96'hA000_A000_A000_A000_A000_A000; READ.
  - required response: that value is returned with a valid pulse.
- Address truncation:
  - stimulus: SMA imm 16'h0578 (still address 376); LOADI C888..C883; COMMIT; READ.
  - required response: 96'hC883_C884_C885_C886_C887_C888.
  - follow-up: STOREB 96'hAA00_A000_A000_A000_A000_A000, then READ, returns that value.
- LOADI with reg_a=6 leaves the staging line unchanged: a COMMIT then READ returns the prior line. Unknown opcode 4'b1111 has no effect.
- Reset asserted one cycle after a READ: no abc_valid_out pulse, and abc_out=0. The RAM retains the previously committed line, so a READ after reset at address 0 returns RAM[0].
